// File: rtl/blake_pkg.sv
// Shared BLAKE-512 control definitions: FSM state encoding, round counter
// geometry and the default G-core pipeline latency.
package blake_pkg;

  localparam int unsigned CNT_W     = 7;
  localparam int unsigned CNT_LAST  = 127;
  localparam int unsigned G_LAT_DEF = 2;
  localparam int unsigned DRN_W_DEF = 4;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_LOAD  = 3'd1;
  localparam logic [2:0] ENC_ROUND = 3'd2;
  localparam logic [2:0] ENC_DRAIN = 3'd3;
  localparam logic [2:0] ENC_FINAL = 3'd4;
  localparam logic [2:0] ENC_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ENC_IDLE,
    S_LOAD  = ENC_LOAD,
    S_ROUND = ENC_ROUND,
    S_DRAIN = ENC_DRAIN,
    S_FINAL = ENC_FINAL,
    S_DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/blake_counter.sv
// G-step index counter, sibling of the round controller.
// Ports: clk, rstb (async active-low), round_ing (count enable; clears
// the index when low), counter_idx (current G step), count_done (last step).
module blake_counter
  import blake_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             round_ing,
  output logic [CNT_W-1:0] counter_idx,
  output logic             count_done
);

  logic [CNT_W-1:0] r_idx;

  // Counts while rounds are issuing, self-clears as soon as round_ing drops.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_idx <= '0;
    end else if (round_ing) begin
      r_idx <= r_idx + 1'b1;
    end else begin
      r_idx <= '0;
    end
  end

  assign counter_idx = r_idx;
  assign count_done  = (r_idx == CNT_W'(CNT_LAST));

endmodule

// File: rtl/blake512_round_ctrl.sv
// Control FSM for the single-G-core BLAKE-512 datapath: accepts a message
// block, then sequences v init, 128 G steps, pipeline drain, finalisation
// and digest hand-off.
// Ports:
//   clk, rstb                 clock, async active-low reset
//   blk_valid/blk_last        block offer from upstream; blk_ready accepts
//   count_done / round_ing    handshake with the sibling blake_counter
//   h_init                    load IV into h (combinational, accept cycle)
//   v_load, final_en          datapath strobes
//   busy                      controller not idle
//   dig_valid / dig_ready     digest hand-off
module blake512_round_ctrl
  import blake_pkg::*;
#(
  parameter int unsigned G_LAT = G_LAT_DEF,
  parameter int unsigned DRN_W = DRN_W_DEF
) (
  input  logic clk,
  input  logic rstb,
  input  logic blk_valid,
  input  logic blk_last,
  output logic blk_ready,
  input  logic count_done,
  output logic round_ing,
  output logic h_init,
  output logic v_load,
  output logic final_en,
  output logic busy,
  output logic dig_valid,
  input  logic dig_ready
);

  // Terminal drain count; unused when the G core has no pipeline.
  localparam logic [DRN_W-1:0] DRN_LAST = (G_LAT > 0) ? DRN_W'(G_LAT - 1) : '0;

  state_t           r_state;
  logic [DRN_W-1:0] r_drain_cnt;
  logic             r_last_q;
  logic             r_first_q;
  logic             r_blk_ready;
  logic             r_round_ing;
  logic             r_v_load;
  logic             r_final_en;
  logic             r_busy;
  logic             r_dig_valid;

  // State and registered strobes; each output is set on the transition
  // into the state that owns it so it is valid for that state's cycles.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_last_q    <= 1'b0;
      r_first_q   <= 1'b1;
      r_blk_ready <= 1'b1;
      r_round_ing <= 1'b0;
      r_v_load    <= 1'b0;
      r_final_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_dig_valid <= 1'b0;
    end else begin
      r_v_load   <= 1'b0;
      r_final_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (blk_valid && r_blk_ready) begin
            r_last_q    <= blk_last;
            r_state     <= S_LOAD;
            r_blk_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_v_load    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state     <= S_ROUND;
          r_round_ing <= 1'b1;
        end
        S_ROUND: begin
          if (count_done) begin
            r_round_ing <= 1'b0;
            r_drain_cnt <= '0;
            if (G_LAT > 0) begin
              r_state <= S_DRAIN;
            end else begin
              r_state    <= S_FINAL;
              r_final_en <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRN_LAST) begin
            r_state    <= S_FINAL;
            r_final_en <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_FINAL: begin
          if (r_last_q) begin
            r_state     <= S_DONE;
            r_dig_valid <= 1'b1;
            r_first_q   <= 1'b1;
          end else begin
            // Next block of the same message chains from the current h.
            r_state     <= S_IDLE;
            r_blk_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_first_q   <= 1'b0;
          end
        end
        S_DONE: begin
          if (dig_ready) begin
            r_state     <= S_IDLE;
            r_dig_valid <= 1'b0;
            r_blk_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_blk_ready <= 1'b1;
          r_round_ing <= 1'b0;
          r_busy      <= 1'b0;
          r_dig_valid <= 1'b0;
        end
      endcase
    end
  end

  // IV load must land in the accept cycle, ahead of v_load.
  assign h_init    = blk_valid & r_blk_ready & r_first_q;

  assign blk_ready = r_blk_ready;
  assign round_ing = r_round_ing;
  assign v_load    = r_v_load;
  assign final_en  = r_final_en;
  assign busy      = r_busy;
  assign dig_valid = r_dig_valid;

endmodule

// File: tb/tb_blake512_round_ctrl.sv
// Bench for blake512_round_ctrl: instance 0 uses G_LAT=2, instance 1 uses
// G_LAT=0, each paired with a blake_counter. A timeline model (cycles since
// accept) predicts every output on every cycle.
module tb_blake512_round_ctrl;
  import blake_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb;
  logic [1:0] bv, bl, dr, spur;
  logic [1:0] w_ready, w_cd_raw, w_cd, w_round, w_hinit, w_vload, w_final, w_busy, w_dig;
  logic [CNT_W-1:0] w_idx0, w_idx1;
  bit   rand_dr;

  assign w_cd = w_cd_raw | spur;

  blake512_round_ctrl #(.G_LAT(2), .DRN_W(4)) u_dut0 (
    .clk(clk), .rstb(rstb), .blk_valid(bv[0]), .blk_last(bl[0]), .blk_ready(w_ready[0]),
    .count_done(w_cd[0]), .round_ing(w_round[0]), .h_init(w_hinit[0]), .v_load(w_vload[0]),
    .final_en(w_final[0]), .busy(w_busy[0]), .dig_valid(w_dig[0]), .dig_ready(dr[0])
  );
  blake_counter u_cnt0 (
    .clk(clk), .rstb(rstb), .round_ing(w_round[0]), .counter_idx(w_idx0), .count_done(w_cd_raw[0])
  );

  blake512_round_ctrl #(.G_LAT(0), .DRN_W(4)) u_dut1 (
    .clk(clk), .rstb(rstb), .blk_valid(bv[1]), .blk_last(bl[1]), .blk_ready(w_ready[1]),
    .count_done(w_cd[1]), .round_ing(w_round[1]), .h_init(w_hinit[1]), .v_load(w_vload[1]),
    .final_en(w_final[1]), .busy(w_busy[1]), .dig_valid(w_dig[1]), .dig_ready(dr[1])
  );
  blake_counter u_cnt1 (
    .clk(clk), .rstb(rstb), .round_ing(w_round[1]), .counter_idx(w_idx1), .count_done(w_cd_raw[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int i, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc=%0d got=%b exp=%b", name, i, cyc, got, exp);
  endtask

  task automatic chk_int(input string name, input int i, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s inst%0d cyc=%0d got=%0d exp=%0d", name, i, cyc, got, exp);
  endtask

  function automatic int glat(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Model: idle, or active with t = cycles since the accept cycle.
  bit m_act   [2];
  int m_t     [2];
  bit m_last  [2];
  bit m_first [2];
  int rlen    [2];
  int acc     [2];
  bit dv_prev [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int fin_t;
      fin_t = 130 + glat(i);
      if (!rstb) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_last[i] = 1'b0; m_first[i] = 1'b1;
        rlen[i] = 0; dv_prev[i] = 1'b0;
      end
      chk("blk_ready", i, w_ready[i], !m_act[i]);
      chk("h_init",    i, w_hinit[i], !m_act[i] && bv[i] && m_first[i]);
      chk("v_load",    i, w_vload[i], m_act[i] && m_t[i] == 1);
      chk("round_ing", i, w_round[i], m_act[i] && m_t[i] >= 2 && m_t[i] <= 129);
      chk("final_en",  i, w_final[i], m_act[i] && m_t[i] == fin_t);
      chk("dig_valid", i, w_dig[i],   m_act[i] && m_t[i] > fin_t);
      chk("busy",      i, w_busy[i],  m_act[i]);

      // Hand-computed latency pins, independent of the model timeline.
      if (bv[i] && w_ready[i]) acc[i] = cyc;
      if (w_final[i]) chk_int("final_lat", i, cyc - acc[i], (i == 0) ? 132 : 130);
      if (w_dig[i] && !dv_prev[i]) chk_int("dig_lat", i, cyc - acc[i], (i == 0) ? 133 : 131);
      dv_prev[i] = w_dig[i];
      if (w_round[i]) rlen[i]++;
      else if (rlen[i] != 0) begin
        chk_int("round_len", i, rlen[i], 128);
        rlen[i] = 0;
      end

      // Advance to the next cycle using inputs the DUT samples at the edge.
      if (!m_act[i]) begin
        if (bv[i]) begin m_act[i] = 1'b1; m_t[i] = 1; m_last[i] = bl[i]; end
      end else if (m_t[i] == fin_t) begin
        if (m_last[i]) begin m_first[i] = 1'b1; m_t[i]++; end
        else begin m_first[i] = 1'b0; m_act[i] = 1'b0; end
      end else if (m_t[i] > fin_t) begin
        if (dr[i]) m_act[i] = 1'b0;
      end else begin
        m_t[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_dr) dr = 2'($urandom_range(0, 3));
  endtask

  task automatic send_block(input int i, input bit last, input bit spur_load);
    bit ok;
    ok = 1'b0;
    bv[i] = 1'b1;
    bl[i] = last;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      if (w_ready[i]) ok = 1'b1;
      tick();
    end
    bv[i] = 1'b0;
    chk("accept_timeout", i, ok, 1'b1);
    if (ok && spur_load) begin
      spur[i] = 1'b1;
      tick();
      spur[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 1000 && w_busy[i]; n++) tick();
    chk("idle_timeout", i, w_busy[i], 1'b0);
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      chk("rst_blk_ready", i, w_ready[i], 1'b1);
      chk("rst_h_init",    i, w_hinit[i], 1'b0);
      chk("rst_v_load",    i, w_vload[i], 1'b0);
      chk("rst_round_ing", i, w_round[i], 1'b0);
      chk("rst_final_en",  i, w_final[i], 1'b0);
      chk("rst_busy",      i, w_busy[i],  1'b0);
      chk("rst_dig_valid", i, w_dig[i],   1'b0);
    end
    chk_int("rst_idx0", 0, int'(w_idx0), 0);
    chk_int("rst_idx1", 1, int'(w_idx1), 0);
  endtask

  initial begin
    bit seen;
    rstb = 1'b0; bv = '0; bl = '0; dr = '0; spur = '0; rand_dr = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    rstb = 1'b1;
    tick();

    // Single-block message with 10 cycles of digest backpressure.
    send_block(0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin tick(); seen = w_dig[0]; end
    chk("dig_wait_timeout", 0, seen, 1'b1);
    repeat (10) tick();
    dr[0] = 1'b1;
    wait_idle(0);

    // Three-block message; next block offered while rounds run, plus a
    // spurious count_done pulse in LOAD.
    send_block(0, 1'b0, 1'b1);
    send_block(0, 1'b0, 1'b0);
    send_block(0, 1'b1, 1'b1);
    wait_idle(0);

    // Asynchronous reset part-way through the G steps.
    send_block(0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin tick(); seen = (w_idx0 == 7'd60); end
    chk("idx60_timeout", 0, seen, 1'b1);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    #2 rstb = 1'b1;
    tick();
    bv[0] = 1'b1; bl[0] = 1'b1;
    #1 chk("h_init_after_rst", 0, w_hinit[0], 1'b1);
    send_block(0, 1'b1, 1'b0);
    wait_idle(0);

    // G_LAT=0 instance: FINAL directly after count_done.
    dr[1] = 1'b1;
    send_block(1, 1'b1, 1'b0);
    wait_idle(1);
    send_block(1, 1'b0, 1'b1);
    send_block(1, 1'b1, 1'b0);
    wait_idle(1);

    // Randomized traffic with random digest backpressure.
    rand_dr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_block(k % 2, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    rand_dr = 1'b0;
    dr = 2'b11;
    wait_idle(0);
    wait_idle(1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
